// File: rtl/pkg_config.sv
// Shared configuration for the integer core: data/register sizes, write-back
// defaults, load funct3 encodings and the load extension helper.
package pkg_config;

  localparam int DATA_WIDTH      = 32;
  localparam int NUM_REGISTER    = 32;
  localparam int REG_AW          = $clog2(NUM_REGISTER);
  localparam int WB_FIFO_DEPTH   = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_op_e;

  typedef struct packed {
    logic [REG_AW-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Halfword lane uses only byte_off[1]; unknown funct3 passes the word through.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [2:0]            funct3,
    input logic [1:0]            byte_off,
    input logic [DATA_WIDTH-1:0] word
  );
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] result;
    lane_b = 8'(word >> {byte_off, 3'b000});
    lane_h = 16'(word >> {byte_off[1], 4'b0000});
    case (funct3)
      LOAD_LB:  result = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      LOAD_LH:  result = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      LOAD_LBU: result = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      LOAD_LHU: result = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      LOAD_LW:  result = word;
      default:  result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load response buffer for the write-back stage: small synchronous FIFO with a
// registered occupancy count; pushes into a full FIFO are dropped.
module wb_load_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr_reg];

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register file write-port front end: ALU results win arbitration over buffered
// loads, with an anti-starvation stall. Optional forwarding under `WB_FWD_EN`.
module regfile_writeback
  import pkg_config::*;
#(
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_AW-1:0]     alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_AW-1:0]     lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [1:0]            lsu_byte_off_i,
  output logic                  rf_we_o,
  output logic [REG_AW-1:0]     rf_rd_addr_o,
  output logic [DATA_WIDTH-1:0] rf_rd_o,
  output logic                  pending_o
`ifdef WB_FWD_EN
  ,
  input  logic [REG_AW-1:0]     rs1_addr_i,
  input  logic [REG_AW-1:0]     rs2_addr_i,
  output logic                  fwd_rs1_hit_o,
  output logic                  fwd_rs2_hit_o,
  output logic [DATA_WIDTH-1:0] fwd_rs1_o,
  output logic [DATA_WIDTH-1:0] fwd_rs2_o
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             push_entry, head_entry;
  logic                  fifo_full, fifo_empty;
  logic                  alu_xfer, lsu_push, fifo_pop;
  logic                  alu_ready_reg;
  logic [SW-1:0]         starve_reg, starve_next;
  logic                  rf_we_reg, rf_we_next;
  logic [REG_AW-1:0]     rf_addr_reg, rf_addr_next;
  logic [DATA_WIDTH-1:0] rf_data_reg, rf_data_next;

  assign alu_ready_o = alu_ready_reg;
  assign lsu_ready_o = !fifo_full;
  assign pending_o   = !fifo_empty;

  assign alu_xfer = alu_valid_i && alu_ready_reg;
  assign lsu_push = lsu_valid_i && !fifo_full;
  assign fifo_pop = !alu_xfer && !fifo_empty;

  assign push_entry = '{rd_addr: lsu_rd_addr_i,
                        data:    load_extend(lsu_funct3_i, lsu_byte_off_i, lsu_data_i)};

  wb_load_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_load_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (lsu_push),
    .pop_i   (fifo_pop),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Counts cycles a waiting load lost to the ALU; reaching the limit blocks
  // the ALU for one cycle, which forces the head to pop.
  always_comb begin
    starve_next = starve_reg;
    if (fifo_empty || fifo_pop) starve_next = '0;
    else if (alu_xfer)          starve_next = starve_reg + 1'b1;
  end

  always_comb begin
    rf_we_next   = 1'b0;
    rf_addr_next = rf_addr_reg;
    rf_data_next = rf_data_reg;
    if (alu_xfer) begin
      rf_we_next   = (alu_rd_addr_i != '0);
      rf_addr_next = alu_rd_addr_i;
      rf_data_next = alu_data_i;
    end else if (fifo_pop) begin
      rf_we_next   = (head_entry.rd_addr != '0);
      rf_addr_next = head_entry.rd_addr;
      rf_data_next = head_entry.data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_reg    <= '0;
      alu_ready_reg <= 1'b1;
      rf_we_reg     <= 1'b0;
      rf_addr_reg   <= '0;
      rf_data_reg   <= '0;
    end else begin
      starve_reg    <= starve_next;
      alu_ready_reg <= (starve_next != SW'(STARVE_LIMIT));
      rf_we_reg     <= rf_we_next;
      rf_addr_reg   <= rf_addr_next;
      rf_data_reg   <= rf_data_next;
    end
  end

  assign rf_we_o      = rf_we_reg;
  assign rf_rd_addr_o = rf_addr_reg;
  assign rf_rd_o      = rf_data_reg;

`ifdef WB_FWD_EN
  // Bridges the cycle where the register file still returns the old value.
  assign fwd_rs1_hit_o = rf_we_reg && (rf_addr_reg == rs1_addr_i) && (rs1_addr_i != '0);
  assign fwd_rs2_hit_o = rf_we_reg && (rf_addr_reg == rs2_addr_i) && (rs2_addr_i != '0);
  assign fwd_rs1_o     = rf_data_reg;
  assign fwd_rs2_o     = rf_data_reg;
`endif

endmodule
